// File: rtl/pulse_spacer.sv
// Rate limiter for pulse_synchronizer: queues incoming event pulses and re-emits
// them one at a time with at least MIN_GAP idle clk1 cycles between outputs.
module pulse_spacer #(
  parameter int CNT_W   = 4,
  parameter int MIN_GAP = 3
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in,
  input  logic             clr_ovf,
  output logic             out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_PEND = '1;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;
  logic             dec;
  logic             accept;
  logic             drop;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
    end
  end

  // dec marks the edge on which a queued event is committed to an output pulse
  always_comb begin
    state_nxt = state;
    gap_nxt   = gap_cnt;
    dec       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending != '0) begin
          state_nxt = PULSE;
          dec       = 1'b1;
        end
      end
      PULSE: begin
        state_nxt = GAP;
        gap_nxt   = GAP_LOAD;
      end
      GAP: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end else if (pending != '0) begin
          state_nxt = PULSE;
          dec       = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A full queue still accepts an event when a slot frees up on the same edge
  assign accept = in & ((pending != MAX_PEND) | dec);
  assign drop   = in & ~accept;

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept && !dec) begin
        pending <= pending + CNT_W'(1);
      end else if (dec && !accept) begin
        pending <= pending - CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    out  = (state == PULSE);
    busy = (pending != '0) | (state != IDLE);
  end

endmodule
